// File: rtl/ks_data_path_gen.sv
// K&S datapath: instruction/program-counter registers, register file,
// flag register, ALU and a sequential shift-add multiplier.

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE,
    I_ADD, I_SUB, I_AND, I_OR, I_MUL,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNNEG, I_BNZERO,
    I_HALT
  } decoded_instruction_type;
endpackage

module ks_data_path_gen
  import k_and_s_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned REG_AW = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [2:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic                    mul_start,
  output logic                    mul_busy,
  output logic                    mul_done,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  localparam int unsigned NREGS = 2**REG_AW;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mul_state_t;

  logic [DATA_W-1:0]   ir;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [7:0]          opcode;
  logic [REG_AW-1:0]   f0, f1, f2, lreg;
  logic [ADDR_W-1:0]   madr, mem_addr;
  logic [REG_AW-1:0]   a_addr, b_addr, c_addr;
  logic [DATA_W-1:0]   bus_a, bus_b, bus_c, alu_out;
  logic [DATA_W:0]     sum;
  logic                uov_next, sov_next;
  logic                ir_unused_bits;

  mul_state_t          mstate;
  logic [2*DATA_W-1:0] mcand, product;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    count;

  assign opcode = ir[DATA_W-1 -: 8];
  assign f0     = ir[REG_AW-1:0];
  assign f1     = ir[2*REG_AW-1 -: REG_AW];
  assign f2     = ir[3*REG_AW-1 -: REG_AW];
  assign madr   = ir[ADDR_W-1:0];
  assign lreg   = ir[ADDR_W+REG_AW-1 -: REG_AW];
  assign ir_unused_bits = ^ir;

  // Instruction decode: opcode to instruction plus register/address fields
  always_comb begin
    decoded_instruction = I_NOP;
    a_addr   = '0;
    b_addr   = '0;
    c_addr   = '0;
    mem_addr = '0;
    case (opcode)
      8'h81: begin decoded_instruction = I_LOAD;  c_addr = lreg; mem_addr = madr; end
      8'h82: begin decoded_instruction = I_STORE; a_addr = lreg; mem_addr = madr; end
      8'h91: begin decoded_instruction = I_MOVE;  a_addr = f0; b_addr = f0; c_addr = f1; end
      8'hA1: begin decoded_instruction = I_ADD; a_addr = f0; b_addr = f1; c_addr = f2; end
      8'hA2: begin decoded_instruction = I_SUB; a_addr = f0; b_addr = f1; c_addr = f2; end
      8'hA3: begin decoded_instruction = I_AND; a_addr = f0; b_addr = f1; c_addr = f2; end
      8'hA4: begin decoded_instruction = I_OR;  a_addr = f0; b_addr = f1; c_addr = f2; end
      8'hA5: begin decoded_instruction = I_MUL; a_addr = f0; b_addr = f1; c_addr = f2; end
      8'h01: begin decoded_instruction = I_BRANCH; mem_addr = madr; end
      8'h02: begin decoded_instruction = I_BZERO;  mem_addr = madr; end
      8'h03: begin decoded_instruction = I_BNEG;   mem_addr = madr; end
      8'h05: begin decoded_instruction = I_BOV;    mem_addr = madr; end
      8'h0A: begin decoded_instruction = I_BNNEG;  mem_addr = madr; end
      8'h0B: begin decoded_instruction = I_BNZERO; mem_addr = madr; end
      8'hFF: decoded_instruction = I_HALT;
      default: ;
    endcase
  end

  assign bus_a    = regs[a_addr];
  assign bus_b    = regs[b_addr];
  assign bus_c    = c_sel ? data_in : alu_out;
  assign data_out = bus_a;
  assign ram_addr = addr_sel ? mem_addr : pc;

  // ALU result and overflow flags for the selected operation
  always_comb begin
    alu_out  = '0;
    sum      = '0;
    uov_next = 1'b0;
    sov_next = 1'b0;
    case (operation)
      3'b000: begin
        sum      = {1'b0, bus_a} + {1'b0, bus_b};
        alu_out  = sum[DATA_W-1:0];
        uov_next = sum[DATA_W];
        sov_next = (bus_a[DATA_W-1] == bus_b[DATA_W-1]) && (alu_out[DATA_W-1] != bus_a[DATA_W-1]);
      end
      3'b011: begin
        sum      = {1'b0, bus_a} + {1'b0, ~bus_b} + {{DATA_W{1'b0}}, 1'b1};
        alu_out  = sum[DATA_W-1:0];
        uov_next = ~sum[DATA_W];
        sov_next = (bus_a[DATA_W-1] != bus_b[DATA_W-1]) && (alu_out[DATA_W-1] != bus_a[DATA_W-1]);
      end
      3'b001: alu_out = bus_a & bus_b;
      3'b010: alu_out = bus_a | bus_b;
      3'b100: begin
        alu_out  = product[DATA_W-1:0];
        uov_next = |product[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  // Register file write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write_reg_enable) begin
      regs[c_addr] <= bus_c;
    end
  end

  // Flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else if (flags_reg_enable) begin
      zero_op           <= ~|alu_out;
      neg_op            <= alu_out[DATA_W-1];
      unsigned_overflow <= uov_next;
      signed_overflow   <= sov_next;
    end
  end

  // Program counter and instruction register, independently enabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (pc_enable) pc <= branch ? mem_addr : pc + ADDR_W'(1);
      if (ir_enable) ir <= data_in;
    end
  end

  // Multiplier: one shift-add step per BUSY cycle, then an extra cycle on
  // the terminal count before DONE so mul_done lands DATA_W+1 edges after start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstate   <= M_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      product  <= '0;
      count    <= '0;
      mul_busy <= 1'b0;
      mul_done <= 1'b0;
    end else begin
      case (mstate)
        M_IDLE: begin
          mul_done <= 1'b0;
          if (mul_start) begin
            mcand    <= {{DATA_W{1'b0}}, bus_a};
            mplier   <= bus_b;
            product  <= '0;
            count    <= '0;
            mul_busy <= 1'b1;
            mstate   <= M_BUSY;
          end
        end
        M_BUSY: begin
          if (count == CNT_W'(DATA_W)) begin
            mul_busy <= 1'b0;
            mul_done <= 1'b1;
            mstate   <= M_DONE;
          end else begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
          end
        end
        M_DONE: begin
          mul_done <= 1'b0;
          mstate   <= M_IDLE;
        end
        default: mstate <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ks_data_path_gen.sv
// Scoreboard bench for ks_data_path_gen with directed instruction sequences.
module tb_ks_data_path_gen;
  import k_and_s_pkg::*;

  localparam int DW = 16;
  localparam int AW = 5;

  localparam int K_DATA  = 0;
  localparam int K_FLAGS = 1;
  localparam int K_ADDR  = 2;
  localparam int K_DEC   = 3;
  localparam int K_BUSY  = 4;

  logic clk = 1'b0;
  logic rst_n, branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [2:0] operation;
  logic write_reg_enable, flags_reg_enable, mul_start, mul_busy, mul_done;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] data_out, data_in;

  ks_data_path_gen #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .mul_start(mul_start),
    .mul_busy(mul_busy), .mul_done(mul_done),
    .decoded_instruction(decoded_instruction), .zero_op(zero_op),
    .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .ram_addr(ram_addr),
    .data_out(data_out), .data_in(data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] want;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [15:0] observe(int kind);
    case (kind)
      K_DATA:  return data_out;
      K_FLAGS: return {12'h000, zero_op, neg_op, unsigned_overflow, signed_overflow};
      K_ADDR:  return {11'h000, ram_addr};
      K_DEC:   return {12'h000, 4'(decoded_instruction)};
      default: return {15'h0000, mul_busy};
    endcase
  endfunction

  // Monitor: drain due expectations and check every mul_done pulse
  initial begin
    exp_t e;
    logic [15:0] act;
    int d;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        act = observe(e.kind);
        n_cmp++;
        if (act !== e.want) begin
          n_err++;
          $display("FAIL %s: got %h want %h", e.name, act, e.want);
        end
      end
      if (mul_done === 1'b1) begin
        n_cmp++;
        if (done_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_mul_done: got pulse at cycle %0d want none", cyc);
        end else begin
          d = done_q.pop_front();
          if (d != cyc) begin
            n_err++;
            $display("FAIL mul_done_cycle: got %0d want %0d", cyc, d);
          end
        end
      end
    end
  end

  task automatic expect_now(int kind, logic [15:0] want, string name);
    exp_t e;
    e.due = cyc; e.kind = kind; e.want = want; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
    operation = 3'b000; write_reg_enable = 0; flags_reg_enable = 0; mul_start = 0;
  endtask

  task automatic load_ir(logic [15:0] v);
    data_in = v; ir_enable = 1; step(); ir_enable = 0;
  endtask

  task automatic write_reg(int r, logic [15:0] v);
    load_ir(16'h8100 | 16'(r * 32));
    data_in = v; c_sel = 1; write_reg_enable = 1; step();
    c_sel = 0; write_reg_enable = 0;
  endtask

  task automatic alu(logic [15:0] instr, logic [2:0] op);
    load_ir(instr);
    operation = op; write_reg_enable = 1; flags_reg_enable = 1; step();
    operation = 3'b000; write_reg_enable = 0; flags_reg_enable = 0;
  endtask

  task automatic check_reg(int r, logic [15:0] v, string name);
    load_ir(16'h8200 | 16'(r * 32));
    expect_now(K_DATA, v, name);
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (mul_done !== 1'b1 && n < 40) begin step(); n++; end
    if (mul_done !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got no mul_done want pulse within 40 cycles", name);
    end
  endtask

  initial begin
    idle();
    data_in = 16'h0000;
    // Reset with every enable asserted
    rst_n = 0; pc_enable = 1; ir_enable = 1; write_reg_enable = 1; flags_reg_enable = 1;
    mul_start = 1; branch = 1; data_in = 16'hA124;
    step(); step();
    rst_n = 1; idle();
    expect_now(K_ADDR, 16'h0000, "reset_pc");
    expect_now(K_DEC, 16'(I_NOP), "reset_decode");
    expect_now(K_FLAGS, 16'h0000, "reset_flags");
    expect_now(K_BUSY, 16'h0000, "reset_busy");
    step();

    // ADD: 0x7FFF + 1 and 0xFFFF + 1
    write_reg(0, 16'h7FFF); write_reg(1, 16'h0001);
    alu(16'hA124, 3'b000);
    expect_now(K_FLAGS, 16'h0005, "add_sov_flags");
    check_reg(2, 16'h8000, "add_sov_result");
    write_reg(0, 16'hFFFF);
    alu(16'hA124, 3'b000);
    expect_now(K_FLAGS, 16'h000A, "add_carry_flags");
    check_reg(2, 16'h0000, "add_carry_result");

    // SUB: 3 - 5 into R3
    write_reg(0, 16'h0003); write_reg(1, 16'h0005);
    alu(16'hA234, 3'b011);
    expect_now(K_FLAGS, 16'h0006, "sub_borrow_flags");
    check_reg(3, 16'hFFFE, "sub_borrow_result");

    // AND into R2, OR into R3
    write_reg(0, 16'hF0F0); write_reg(1, 16'hFF00);
    alu(16'hA324, 3'b001);
    expect_now(K_FLAGS, 16'h0004, "and_flags");
    check_reg(2, 16'hF000, "and_result");
    alu(16'hA434, 3'b010);
    expect_now(K_FLAGS, 16'h0004, "or_flags");
    check_reg(3, 16'hFFF0, "or_result");

    // MUL 0x0123 * 0x0010 with a stray start and operand overwrites while busy
    write_reg(0, 16'h0123); write_reg(1, 16'h0010);
    load_ir(16'hA524);
    mul_start = 1; step(); mul_start = 0;
    done_q.push_back(cyc + 17);
    expect_now(K_BUSY, 16'h0001, "mul_busy_after_start");
    step(); step(); step();
    mul_start = 1; step(); mul_start = 0;
    write_reg(0, 16'hFFFF); write_reg(1, 16'h0000);
    wait_done("mul1_timeout");
    alu(16'hA524, 3'b100);
    expect_now(K_FLAGS, 16'h0000, "mul1_flags");
    check_reg(2, 16'h1230, "mul1_result");

    // MUL 0x8000 * 4: product low half zero, high half nonzero
    write_reg(0, 16'h8000); write_reg(1, 16'h0004);
    load_ir(16'hA524);
    mul_start = 1; step(); mul_start = 0;
    done_q.push_back(cyc + 17);
    wait_done("mul2_timeout");
    alu(16'hA524, 3'b100);
    expect_now(K_FLAGS, 16'h000A, "mul2_flags");
    check_reg(2, 16'h0000, "mul2_result");

    // Reset in the middle of a multiply
    load_ir(16'hA524);
    mul_start = 1; step(); mul_start = 0;
    step(); step(); step(); step();
    rst_n = 0; step(); rst_n = 1;
    expect_now(K_BUSY, 16'h0000, "busy_cleared_by_reset");
    repeat (25) step();
    write_reg(2, 16'h5555);
    alu(16'hA524, 3'b100);
    expect_now(K_FLAGS, 16'h0008, "product_cleared_flags");
    check_reg(2, 16'h0000, "product_cleared_result");

    // PC increment, wrap, branch and address select
    load_ir(16'h0000);
    pc_enable = 1; repeat (31) step(); pc_enable = 0;
    expect_now(K_ADDR, 16'd31, "pc_31");
    step();
    pc_enable = 1; step(); pc_enable = 0;
    expect_now(K_ADDR, 16'h0000, "pc_wrap");
    load_ir(16'h0112);
    expect_now(K_DEC, 16'(I_BRANCH), "decode_branch");
    addr_sel = 1;
    expect_now(K_ADDR, 16'h0012, "ram_addr_madr");
    step();
    addr_sel = 0; branch = 1; pc_enable = 1; step(); branch = 0; pc_enable = 0;
    expect_now(K_ADDR, 16'h0012, "pc_branch");
    step();
    data_in = 16'hFF00; ir_enable = 1; pc_enable = 1; step(); idle();
    expect_now(K_ADDR, 16'h0013, "pc_inc_with_ir");
    expect_now(K_DEC, 16'(I_HALT), "decode_halt");
    step(); step();

    n_cmp++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", exp_q.size(), done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
